// File: rtl/t1_retire_monitor_pkg.sv
// Shared types and default constants for the retire monitor and its event FIFO.
package t1_retire_monitor_pkg;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_TIMEOUT_W = 32;
   localparam int CYCLE_W       = 64;
   localparam int RD_IDX_W      = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      TIMEOUT = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic [CYCLE_W-1:0]    cycle;
      logic [RD_IDX_W-1:0]   rd_idx;
      logic [DEF_DATA_W-1:0] rd_data;
   } retire_evt_t;

   // Flattened event width for a given write-back data width.
   function automatic int evt_width(input int data_w);
      return CYCLE_W + RD_IDX_W + data_w;
   endfunction

endpackage

// File: rtl/t1_retire_fifo.sv
// Synchronous valid/ready FIFO; head is read straight from storage, so a push
// becomes visible on the read side one cycle later.
module t1_retire_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [W-1:0]           push_data,
   output logic                   pop_valid,
   input  logic                   pop_ready,
   output logic [W-1:0]           pop_data,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign push_ready = (r_count != FULL_CNT);
   assign pop_valid  = (r_count != {(AW+1){1'b0}});
   assign pop_data   = r_mem[r_rd_ptr];
   assign occupancy  = r_count;
   assign w_push     = push_valid & push_ready;
   assign w_pop      = pop_ready & pop_valid;

   // Pointers and fill level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/t1_retire_monitor.sv
// Retire monitor: timestamps accepted retires into an event FIFO, counts them,
// and runs a sticky stall watchdog between retires.
module t1_retire_monitor
   import t1_retire_monitor_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [TIMEOUT_W-1:0]   timeout_limit,
   input  logic                   retire_valid,
   output logic                   retire_ready,
   input  logic [4:0]             retire_rd_idx,
   input  logic [DATA_W-1:0]      retire_rd_data,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [63:0]            evt_cycle,
   output logic [4:0]             evt_rd_idx,
   output logic [DATA_W-1:0]      evt_rd_data,
   output logic [63:0]            retire_count,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   timeout
);

   localparam int EVT_W = evt_width(DATA_W);
   localparam logic [TIMEOUT_W-1:0] STALL_MAX  = {TIMEOUT_W{1'b1}};
   localparam logic [TIMEOUT_W-1:0] STALL_ZERO = {TIMEOUT_W{1'b0}};

   mon_state_e           r_state;
   mon_state_e           w_state_nxt;
   logic [63:0]          r_cycle;
   logic [63:0]          r_retire_count;
   logic [TIMEOUT_W-1:0] r_stall;
   logic [TIMEOUT_W-1:0] w_stall_nxt;
   logic                 w_fifo_ready;
   logic                 w_fifo_valid;
   logic                 w_accept;
   logic                 w_limit_hit;
   logic [EVT_W-1:0]     w_push_data;
   logic [EVT_W-1:0]     w_pop_data;

   // Handshake outputs come from registered state; reset forces them low.
   assign retire_ready = !reset && w_fifo_ready && (r_state != TIMEOUT);
   assign w_accept     = retire_valid && retire_ready;
   assign evt_valid    = !reset && w_fifo_valid;
   assign timeout      = !reset && (r_state == TIMEOUT);
   assign retire_count = r_retire_count;
   assign w_push_data  = {r_cycle, retire_rd_idx, retire_rd_data};
   assign {evt_cycle, evt_rd_idx, evt_rd_data} = w_pop_data;
   assign w_limit_hit  = (timeout_limit != STALL_ZERO) && (r_stall == timeout_limit);

   t1_retire_fifo #(
      .DEPTH (DEPTH),
      .W     (EVT_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_valid (w_accept),
      .push_ready (w_fifo_ready),
      .push_data  (w_push_data),
      .pop_valid  (w_fifo_valid),
      .pop_ready  (evt_ready),
      .pop_data   (w_pop_data),
      .occupancy  (occupancy)
   );

   // Watchdog next state; disarming takes priority over an expiring limit.
   always_comb begin
      w_state_nxt = r_state;
      w_stall_nxt = r_stall;
      case (r_state)
         IDLE: begin
            w_stall_nxt = STALL_ZERO;
            if (enable) w_state_nxt = RUN;
            else        w_state_nxt = IDLE;
         end
         RUN: begin
            if (w_accept)                  w_stall_nxt = STALL_ZERO;
            else if (r_stall != STALL_MAX) w_stall_nxt = r_stall + TIMEOUT_W'(1'b1);
            else                           w_stall_nxt = r_stall;
            if (!enable)                      w_state_nxt = IDLE;
            else if (w_limit_hit && !w_accept) w_state_nxt = TIMEOUT;
            else                              w_state_nxt = RUN;
         end
         TIMEOUT: w_state_nxt = TIMEOUT;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, stall, cycle and retire counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_stall        <= STALL_ZERO;
         r_cycle        <= 64'd0;
         r_retire_count <= 64'd0;
      end else begin
         r_state <= w_state_nxt;
         r_stall <= w_stall_nxt;
         r_cycle <= r_cycle + 64'd1;
         if (w_accept) r_retire_count <= r_retire_count + 64'd1;
      end
   end

endmodule
